id_pipe_stage: RTL and testbench

Registered, parametrised instruction-decode stage for the pipelined core. It accepts one fetched instruction per cycle from IF over a valid/ready handshake and decodes it into register indices, a single selected immediate and control bits. The result is held in an ID/EX pipeline register. The stage adds load-use hazard stalling, EX backpressure, branch/jump flush, a sticky halt on illegal instructions and a saturating stall counter; it sits between the fetch stage and the execute stage.

---
 rtl/core_pkg.sv | 54 +++++
 rtl/id_control.sv | 75 +++++++
 rtl/id_decoder.sv | 27 ++
 rtl/id_hazard_detect.sv | 17 +
 rtl/id_pipe_stage.sv | 127 ++++++++++++
 tb/tb_id_pipe_stage.sv | 185 ++++++++++++++++++
 6 files changed

// File: rtl/core_pkg.sv
// core_pkg: shared opcodes, operation encodings and control-word types for the core
package core_pkg;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR,
    ALU_SRL, ALU_SRA, ALU_OR, ALU_AND, ALU_PASS_B
  } alu_op_e;

  // Branch encodings mirror funct3 so the comparator can use them directly.
  typedef enum logic [3:0] {
    BR_EQ = 4'd0, BR_NE = 4'd1, BR_LT = 4'd4, BR_GE = 4'd5,
    BR_LTU = 4'd6, BR_GEU = 4'd7, BR_NONE = 4'd15
  } br_op_e;

  typedef enum logic [2:0] {IMM_NONE, IMM_I, IMM_S, IMM_B, IMM_U, IMM_J} imm_fmt_e;

  typedef struct packed {
    logic     alu_op;
    logic     write_reg;
    logic     load;
    logic     store;
    logic     branch;
    logic     jump;
    logic     panic;
    logic     uses_rs1;
    logic     uses_rs2;
    alu_op_e  alu_op_type;
    br_op_e   branch_type;
    imm_fmt_e imm_fmt;
  } ctrl_t;

  // alt selects SUB/SRA; callers decide when funct7[5] is meaningful.
  function automatic alu_op_e alu_sel(input logic [2:0] f3, input logic alt);
    case (f3)
      3'd0:    return alt ? ALU_SUB : ALU_ADD;
      3'd1:    return ALU_SLL;
      3'd2:    return ALU_SLT;
      3'd3:    return ALU_SLTU;
      3'd4:    return ALU_XOR;
      3'd5:    return alt ? ALU_SRA : ALU_SRL;
      3'd6:    return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction
endpackage

// File: rtl/id_control.sv
// id_control: maps opcode/funct fields to the control word
module id_control
  import core_pkg::*;
(
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       funct7_5,
  output ctrl_t      ctrl
);
  // Unknown opcodes and reserved branch funct3 values raise panic.
  always_comb begin
    ctrl = '0;
    ctrl.alu_op_type = ALU_ADD;
    ctrl.branch_type = BR_NONE;
    ctrl.imm_fmt = IMM_NONE;
    ctrl.uses_rs1 = 1'b1;
    case (opcode)
      OPC_OP: begin
        ctrl.alu_op = 1'b1;
        ctrl.write_reg = 1'b1;
        ctrl.uses_rs2 = 1'b1;
        ctrl.alu_op_type = alu_sel(funct3, funct7_5);
      end
      OPC_OP_IMM: begin
        ctrl.alu_op = 1'b1;
        ctrl.write_reg = 1'b1;
        ctrl.imm_fmt = IMM_I;
        ctrl.alu_op_type = alu_sel(funct3, funct3 == 3'd5 && funct7_5);
      end
      OPC_LOAD: begin
        ctrl.write_reg = 1'b1;
        ctrl.load = 1'b1;
        ctrl.imm_fmt = IMM_I;
      end
      OPC_STORE: begin
        ctrl.store = 1'b1;
        ctrl.uses_rs2 = 1'b1;
        ctrl.imm_fmt = IMM_S;
      end
      OPC_BRANCH: begin
        ctrl.branch = 1'b1;
        ctrl.uses_rs2 = 1'b1;
        ctrl.imm_fmt = IMM_B;
        ctrl.branch_type = br_op_e'({1'b0, funct3});
        ctrl.panic = funct3[2:1] == 2'b01;
      end
      OPC_JAL: begin
        ctrl.write_reg = 1'b1;
        ctrl.jump = 1'b1;
        ctrl.uses_rs1 = 1'b0;
        ctrl.imm_fmt = IMM_J;
      end
      OPC_JALR: begin
        ctrl.write_reg = 1'b1;
        ctrl.jump = 1'b1;
        ctrl.imm_fmt = IMM_I;
      end
      OPC_LUI: begin
        ctrl.write_reg = 1'b1;
        ctrl.uses_rs1 = 1'b0;
        ctrl.imm_fmt = IMM_U;
        ctrl.alu_op_type = ALU_PASS_B;
      end
      OPC_AUIPC: begin
        ctrl.write_reg = 1'b1;
        ctrl.uses_rs1 = 1'b0;
        ctrl.imm_fmt = IMM_U;
      end
      default: begin
        ctrl.panic = 1'b1;
        ctrl.uses_rs1 = 1'b0;
      end
    endcase
  end
endmodule

// File: rtl/id_decoder.sv
// id_decoder: splits an instruction word into fields and all candidate immediates
module id_decoder (
  input  logic [31:0] instr,
  output logic [6:0]  opcode,
  output logic [4:0]  rd,
  output logic [4:0]  rs1,
  output logic [4:0]  rs2,
  output logic [2:0]  funct3,
  output logic        funct7_5,
  output logic [31:0] imm_i,
  output logic [31:0] imm_s,
  output logic [31:0] imm_b,
  output logic [31:0] imm_u,
  output logic [31:0] imm_j
);
  assign opcode   = instr[6:0];
  assign rd       = instr[11:7];
  assign funct3   = instr[14:12];
  assign rs1      = instr[19:15];
  assign rs2      = instr[24:20];
  assign funct7_5 = instr[30];
  assign imm_i    = {{20{instr[31]}}, instr[31:20]};
  assign imm_s    = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_b    = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  assign imm_u    = {instr[31:12], 12'b0};
  assign imm_j    = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
endmodule

// File: rtl/id_hazard_detect.sv
// id_hazard_detect: flags a load in EX whose destination feeds the instruction in ID
module id_hazard_detect #(
  parameter int REG_AW = 5,
  parameter bit ENABLE = 1'b1
) (
  input  logic [REG_AW-1:0] rs1,
  input  logic [REG_AW-1:0] rs2,
  input  logic              uses_rs1,
  input  logic              uses_rs2,
  input  logic              ex_valid,
  input  logic              ex_load,
  input  logic [REG_AW-1:0] ex_rd,
  output logic              hazard
);
  assign hazard = ENABLE && ex_valid && ex_load && ex_rd != '0 &&
                  ((uses_rs1 && ex_rd == rs1) || (uses_rs2 && ex_rd == rs2));
endmodule

// File: rtl/id_pipe_stage.sv
// id_pipe_stage: decode stage with ID/EX register, load-use stall, flush and illegal-op halt
module id_pipe_stage #(
  parameter int XLEN = 32,
  parameter int NUM_REGS = 32,
  parameter bit LOAD_USE_STALL = 1'b1,
  parameter int CNT_W = 16,
  localparam int REG_AW = $clog2(NUM_REGS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_valid,
  input  logic [31:0]       if_instruction,
  input  logic [XLEN-1:0]   if_pc,
  output logic              id_ready,
  input  logic              flush,
  input  logic              ex_ready,
  output logic              ex_valid,
  output logic [XLEN-1:0]   ex_pc,
  output logic [REG_AW-1:0] ex_rs1,
  output logic [REG_AW-1:0] ex_rs2,
  output logic [REG_AW-1:0] ex_rd,
  output logic [XLEN-1:0]   ex_imm,
  output logic              ex_alu_op,
  output logic              ex_write_reg,
  output logic              ex_load,
  output logic              ex_store,
  output logic              ex_branch,
  output logic              ex_jump,
  output logic              ex_panic,
  output logic [3:0]        ex_alu_op_type,
  output logic [3:0]        ex_branch_type,
  output logic              halted,
  output logic [CNT_W-1:0]  stall_count
);
  import core_pkg::*;

  logic [6:0]        opcode;
  logic [4:0]        rd_f, rs1_f, rs2_f;
  logic [2:0]        funct3;
  logic              funct7_5;
  logic [31:0]       imm_i, imm_s, imm_b, imm_u, imm_j, imm32;
  ctrl_t             ctrl;
  logic [REG_AW-1:0] rs1, rs2, rd;
  logic [XLEN-1:0]   imm;
  logic              hazard, advance, accept;

  id_decoder u_dec (
    .instr(if_instruction), .opcode, .rd(rd_f), .rs1(rs1_f), .rs2(rs2_f),
    .funct3, .funct7_5, .imm_i, .imm_s, .imm_b, .imm_u, .imm_j
  );

  id_control u_ctl (.opcode, .funct3, .funct7_5, .ctrl);

  id_hazard_detect #(.REG_AW(REG_AW), .ENABLE(LOAD_USE_STALL)) u_haz (
    .rs1, .rs2, .uses_rs1(ctrl.uses_rs1), .uses_rs2(ctrl.uses_rs2),
    .ex_valid, .ex_load, .ex_rd, .hazard
  );

  assign rs1 = rs1_f[REG_AW-1:0];
  assign rs2 = rs2_f[REG_AW-1:0];
  assign rd  = rd_f[REG_AW-1:0];

  // Pick the immediate for the decoded format; formats without one yield zero.
  always_comb begin
    imm32 = ctrl.imm_fmt == IMM_I ? imm_i :
            ctrl.imm_fmt == IMM_S ? imm_s :
            ctrl.imm_fmt == IMM_B ? imm_b :
            ctrl.imm_fmt == IMM_U ? imm_u :
            ctrl.imm_fmt == IMM_J ? imm_j : 32'd0;
  end

  assign imm      = XLEN'(signed'(imm32));
  assign advance  = !ex_valid || ex_ready;
  assign id_ready = !halted && !flush && !hazard && advance;
  assign accept   = if_valid && id_ready;

  // ID/EX register: flush beats bubble beats load beats drain; otherwise hold.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ex_valid       <= 1'b0;
      ex_pc          <= '0;
      ex_rs1         <= '0;
      ex_rs2         <= '0;
      ex_rd          <= '0;
      ex_imm         <= '0;
      ex_alu_op      <= 1'b0;
      ex_write_reg   <= 1'b0;
      ex_load        <= 1'b0;
      ex_store       <= 1'b0;
      ex_branch      <= 1'b0;
      ex_jump        <= 1'b0;
      ex_panic       <= 1'b0;
      ex_alu_op_type <= '0;
      ex_branch_type <= '0;
      stall_count    <= '0;
    end else if (flush) begin
      ex_valid <= 1'b0;
    end else if (hazard && advance) begin
      ex_valid    <= 1'b0;
      stall_count <= &stall_count ? stall_count : stall_count + 1'b1;
    end else if (accept) begin
      ex_valid       <= 1'b1;
      ex_pc          <= if_pc;
      ex_rs1         <= rs1;
      ex_rs2         <= rs2;
      ex_rd          <= rd;
      ex_imm         <= imm;
      ex_alu_op      <= ctrl.alu_op;
      ex_write_reg   <= ctrl.write_reg;
      ex_load        <= ctrl.load;
      ex_store       <= ctrl.store;
      ex_branch      <= ctrl.branch;
      ex_jump        <= ctrl.jump;
      ex_panic       <= ctrl.panic;
      ex_alu_op_type <= ctrl.alu_op_type;
      ex_branch_type <= ctrl.branch_type;
    end else if (advance) begin
      ex_valid <= 1'b0;
    end
  end

  // Halt once an illegal instruction is actually handed to EX; a flush discards it instead.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) halted <= 1'b0;
    else if (ex_valid && ex_panic && ex_ready && !flush) halted <= 1'b1;
  end
endmodule

// File: tb/tb_id_pipe_stage.sv
// tb_id_pipe_stage: directed-vector checks of the decode stage
module tb_id_pipe_stage;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        if_valid = 1'b0;
  logic [31:0] if_instruction = '0;
  logic [31:0] if_pc = '0;
  logic        id_ready;
  logic        flush = 1'b0;
  logic        ex_ready = 1'b0;
  logic        ex_valid;
  logic [31:0] ex_pc;
  logic [4:0]  ex_rs1, ex_rs2, ex_rd;
  logic [31:0] ex_imm;
  logic        ex_alu_op, ex_write_reg, ex_load, ex_store, ex_branch, ex_jump, ex_panic;
  logic [3:0]  ex_alu_op_type, ex_branch_type;
  logic        halted;
  logic [15:0] stall_count;
  int errors = 0;
  int checks = 0;

  id_pipe_stage dut (
    .clk(clk), .reset(reset), .if_valid(if_valid), .if_instruction(if_instruction),
    .if_pc(if_pc), .id_ready(id_ready), .flush(flush), .ex_ready(ex_ready),
    .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
    .ex_imm(ex_imm), .ex_alu_op(ex_alu_op), .ex_write_reg(ex_write_reg), .ex_load(ex_load),
    .ex_store(ex_store), .ex_branch(ex_branch), .ex_jump(ex_jump), .ex_panic(ex_panic),
    .ex_alu_op_type(ex_alu_op_type), .ex_branch_type(ex_branch_type), .halted(halted),
    .stall_count(stall_count)
  );

  always #5 clk = ~clk;

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    #2;
    checks++; if (ex_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %b want 0", ex_valid); end
    checks++; if (halted !== 1'b0) begin errors++; $display("FAIL rst_halted got %b want 0", halted); end
    checks++; if (stall_count !== 16'd0) begin errors++; $display("FAIL rst_stall got %0d want 0", stall_count); end
    checks++; if (ex_imm !== 32'd0 || ex_pc !== 32'd0) begin errors++; $display("FAIL rst_fields got imm %h pc %h want 0", ex_imm, ex_pc); end
    step;
    reset = 1'b0;
    #1;
    checks++; if (id_ready !== 1'b1) begin errors++; $display("FAIL rst_ready got %b want 1", id_ready); end
  endtask

  task automatic test_throughput;
    ex_ready = 1'b1;
    if_valid = 1'b1; if_instruction = 32'h00500093; if_pc = 32'h100;
    #1;
    checks++; if (id_ready !== 1'b1) begin errors++; $display("FAIL thr_ready0 got %b want 1", id_ready); end
    step;
    checks++; if (ex_valid !== 1'b1) begin errors++; $display("FAIL thr_valid0 got %b want 1", ex_valid); end
    checks++; if (ex_imm !== 32'd5) begin errors++; $display("FAIL thr_imm0 got %h want 5", ex_imm); end
    checks++; if (ex_rd !== 5'd1) begin errors++; $display("FAIL thr_rd0 got %0d want 1", ex_rd); end
    checks++; if (ex_pc !== 32'h100) begin errors++; $display("FAIL thr_pc0 got %h want 100", ex_pc); end
    if_instruction = 32'h00700113; if_pc = 32'h104;
    #1;
    checks++; if (id_ready !== 1'b1) begin errors++; $display("FAIL thr_ready1 got %b want 1", id_ready); end
    step;
    checks++; if (ex_valid !== 1'b1) begin errors++; $display("FAIL thr_valid1 got %b want 1", ex_valid); end
    checks++; if (ex_imm !== 32'd7) begin errors++; $display("FAIL thr_imm1 got %h want 7", ex_imm); end
    checks++; if (ex_rd !== 5'd2) begin errors++; $display("FAIL thr_rd1 got %0d want 2", ex_rd); end
    if_valid = 1'b0;
    step;
    checks++; if (ex_valid !== 1'b0) begin errors++; $display("FAIL thr_drain got %b want 0", ex_valid); end
  endtask

  task automatic test_no_false_stall;
    if_valid = 1'b1; if_instruction = 32'h0000A003; if_pc = 32'h200;
    step;
    if_instruction = 32'h001001B3; if_pc = 32'h204;
    #1;
    checks++; if (id_ready !== 1'b1) begin errors++; $display("FAIL nfs_ready got %b want 1", id_ready); end
    step;
    checks++; if (ex_valid !== 1'b1 || ex_rd !== 5'd3) begin errors++; $display("FAIL nfs_add got valid %b rd %0d want 1 3", ex_valid, ex_rd); end
    checks++; if (stall_count !== 16'd0) begin errors++; $display("FAIL nfs_stall got %0d want 0", stall_count); end
  endtask

  task automatic test_load_use;
    if_instruction = 32'h0000A103; if_pc = 32'h300;
    step;
    checks++; if (ex_valid !== 1'b1 || ex_load !== 1'b1 || ex_rd !== 5'd2) begin errors++; $display("FAIL lu_load got valid %b load %b rd %0d want 1 1 2", ex_valid, ex_load, ex_rd); end
    if_instruction = 32'h001101B3; if_pc = 32'h304;
    #1;
    checks++; if (id_ready !== 1'b0) begin errors++; $display("FAIL lu_ready_stall got %b want 0", id_ready); end
    step;
    checks++; if (ex_valid !== 1'b0) begin errors++; $display("FAIL lu_bubble got %b want 0", ex_valid); end
    checks++; if (stall_count !== 16'd1) begin errors++; $display("FAIL lu_stall got %0d want 1", stall_count); end
    checks++; if (id_ready !== 1'b1) begin errors++; $display("FAIL lu_ready_after got %b want 1", id_ready); end
    step;
    checks++; if (ex_valid !== 1'b1 || ex_rd !== 5'd3 || ex_rs1 !== 5'd2 || ex_rs2 !== 5'd1 || ex_pc !== 32'h304) begin
      errors++; $display("FAIL lu_add got valid %b rd %0d rs1 %0d rs2 %0d pc %h want 1 3 2 1 304", ex_valid, ex_rd, ex_rs1, ex_rs2, ex_pc);
    end
    checks++; if (stall_count !== 16'd1) begin errors++; $display("FAIL lu_stall_hold got %0d want 1", stall_count); end
  endtask

  task automatic test_backpressure_flush;
    if_instruction = 32'h00500093; if_pc = 32'h400;
    step;
    ex_ready = 1'b0;
    if_instruction = 32'h00700113; if_pc = 32'h404;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (id_ready !== 1'b0) begin errors++; $display("FAIL bp_ready%0d got %b want 0", i, id_ready); end
      step;
      checks++; if (ex_valid !== 1'b1 || ex_pc !== 32'h400 || ex_imm !== 32'd5 || ex_rd !== 5'd1) begin
        errors++; $display("FAIL bp_hold%0d got valid %b pc %h imm %h rd %0d want 1 400 5 1", i, ex_valid, ex_pc, ex_imm, ex_rd);
      end
    end
    flush = 1'b1;
    #1;
    checks++; if (id_ready !== 1'b0) begin errors++; $display("FAIL fl_ready got %b want 0", id_ready); end
    step;
    flush = 1'b0;
    checks++; if (ex_valid !== 1'b0) begin errors++; $display("FAIL fl_valid got %b want 0", ex_valid); end
    checks++; if (ex_pc !== 32'h400) begin errors++; $display("FAIL fl_noaccept got pc %h want 400", ex_pc); end
    if_valid = 1'b0;
    ex_ready = 1'b1;
    step;
  endtask

  task automatic test_branch_imm;
    if_valid = 1'b1; if_instruction = 32'hFE208EE3; if_pc = 32'h500;
    step;
    checks++; if (ex_imm !== 32'hFFFFFFFC) begin errors++; $display("FAIL br_imm got %h want fffffffc", ex_imm); end
    checks++; if (ex_branch !== 1'b1 || ex_branch_type !== 4'd0) begin errors++; $display("FAIL br_ctrl got branch %b type %0d want 1 0", ex_branch, ex_branch_type); end
    checks++; if (ex_rs1 !== 5'd1 || ex_rs2 !== 5'd2) begin errors++; $display("FAIL br_regs got %0d %0d want 1 2", ex_rs1, ex_rs2); end
    checks++; if (ex_write_reg !== 1'b0 || ex_panic !== 1'b0) begin errors++; $display("FAIL br_flags got wr %b panic %b want 0 0", ex_write_reg, ex_panic); end
  endtask

  task automatic test_illegal;
    if_instruction = 32'hFFFFFFFF; if_pc = 32'h600;
    step;
    checks++; if (ex_valid !== 1'b1 || ex_panic !== 1'b1) begin errors++; $display("FAIL ill_panic got valid %b panic %b want 1 1", ex_valid, ex_panic); end
    checks++; if (halted !== 1'b0) begin errors++; $display("FAIL ill_early_halt got %b want 0", halted); end
    if_valid = 1'b0;
    step;
    checks++; if (halted !== 1'b1) begin errors++; $display("FAIL ill_halted got %b want 1", halted); end
    if_valid = 1'b1; if_instruction = 32'h00500093;
    #1;
    checks++; if (id_ready !== 1'b0) begin errors++; $display("FAIL ill_ready0 got %b want 0", id_ready); end
    step;
    checks++; if (id_ready !== 1'b0 || ex_valid !== 1'b0) begin errors++; $display("FAIL ill_ready1 got ready %b valid %b want 0 0", id_ready, ex_valid); end
    reset = 1'b1;
    #1;
    checks++; if (halted !== 1'b0 || stall_count !== 16'd0) begin errors++; $display("FAIL ill_reset got halted %b stall %0d want 0 0", halted, stall_count); end
    step;
    reset = 1'b0;
    if_valid = 1'b0;
    #1;
  endtask

  task automatic test_flush_panic;
    ex_ready = 1'b0;
    if_valid = 1'b1; if_instruction = 32'hFFFFFFFF;
    step;
    checks++; if (ex_valid !== 1'b1 || ex_panic !== 1'b1) begin errors++; $display("FAIL fp_load got valid %b panic %b want 1 1", ex_valid, ex_panic); end
    if_valid = 1'b0;
    flush = 1'b1;
    step;
    flush = 1'b0;
    ex_ready = 1'b1;
    step;
    checks++; if (halted !== 1'b0) begin errors++; $display("FAIL fp_halted got %b want 0", halted); end
    checks++; if (id_ready !== 1'b1) begin errors++; $display("FAIL fp_ready got %b want 1", id_ready); end
  endtask

  initial begin
    test_reset;
    test_throughput;
    test_no_false_stall;
    test_load_use;
    test_backpressure_flush;
    test_branch_imm;
    test_illegal;
    test_flush_panic;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
